// File: rtl/input_vc_buffer.sv
// Per-VC input buffer for one input-port virtual channel.
// Stores flits in a circular buffer and tracks the packet at the head of the
// buffer through IDLE -> VA (VC allocation) -> SA (switch allocation).
// Upstream flow control is a hysteretic on/off signal driven from occupancy.
// With ALLOW_NEXT_HEAD=1 the head of the following packet may be written while
// the current packet is still draining; its route is parked until the tail pops.
// Optional feature macro: INPUT_VC_BUFFER_STATS_EN adds saturating packet and
// drop counters (pkt_count_o, drop_count_o).

package input_vc_buffer_pkg;

    localparam int VC_SIZE = 2;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef struct packed {
        flit_label_t       flit_label;
        logic [DATA_W-1:0] data;
    } flit_novc_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        logic [DATA_W-1:0]  data;
    } flit_t;

endpackage

module input_vc_buffer
    import input_vc_buffer_pkg::*;
#(
    parameter int BUFFER_SIZE     = 8,
    parameter int OFF_THRESHOLD   = 6,
    parameter int ON_THRESHOLD    = 2,
    parameter bit ALLOW_NEXT_HEAD = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          write_i,
    input  flit_novc_t                    data_i,
    input  port_t                         out_port_i,
    input  logic                          read_i,
    output flit_t                         data_o,
    output logic                          is_full_o,
    output logic                          is_empty_o,
    output logic [$clog2(BUFFER_SIZE):0]  occupancy_o,
    output logic                          on_off_o,
    output logic                          vc_request_o,
    input  logic                          vc_valid_i,
    input  logic [VC_SIZE-1:0]            vc_new_i,
    output logic [VC_SIZE-1:0]            downstream_vc_o,
    output port_t                         out_port_o,
    output logic                          switch_request_o,
    output logic                          vc_allocatable_o,
`ifdef INPUT_VC_BUFFER_STATS_EN
    output logic [15:0]                   pkt_count_o,
    output logic [15:0]                   drop_count_o,
`endif
    output logic                          error_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_VA   = 2'b01,
        S_SA   = 2'b10
    } state_t;

    flit_novc_t         mem [BUFFER_SIZE];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    state_t             state;
    state_t             state_next;
    logic               wr_in_pkt;
    logic               pending_v;
    logic               pending_v_next;
    port_t              pending_port;
    port_t              pending_port_next;
    port_t              out_port_next;
    logic [VC_SIZE-1:0] downstream_vc_next;
    logic               fsm_err;
    logic               alloc_next;

    logic               is_head_w;
    logic               space_ok;
    logic               head_slot_ok;
    logic               push;
    logic               head_push;
    logic               write_err;
    logic               pop;
    logic               tail_pop;
    flit_novc_t         head_flit;

    // Occupancy flags and the head-of-buffer flit; vc_id is the latched downstream VC.
    assign is_full_o   = (count == CNT_W'(BUFFER_SIZE));
    assign is_empty_o  = (count == '0);
    assign occupancy_o = count;
    assign head_flit   = mem[rd_ptr];
    assign data_o      = '{flit_label: head_flit.flit_label,
                           vc_id:      downstream_vc_o,
                           data:       head_flit.data};

    // A slot is available when not full, or when a pop frees one in the same cycle.
    assign pop          = (state == S_SA) && read_i && !is_empty_o;
    assign tail_pop     = pop && ((head_flit.flit_label == TAIL) ||
                                  (head_flit.flit_label == HEADTAIL));
    assign space_ok     = !is_full_o || pop;
    assign is_head_w    = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
    assign head_slot_ok = (state == S_IDLE) || (ALLOW_NEXT_HEAD && !pending_v);
    assign push         = write_i && (is_head_w ? (!wr_in_pkt && space_ok && head_slot_ok)
                                                : (wr_in_pkt && space_ok));
    assign head_push    = push && is_head_w;
    assign write_err    = write_i && !push;
    assign count_next   = count + CNT_W'(push) - CNT_W'(pop);

    // Flit storage: data only, the valid region is defined by the pointers.
    // NOTE: storage array is deliberately not reset; occupancy and pointers decide what is valid, and leaving it out keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers, occupancy and the write-side in-packet flag.
    // NOTE: every sequential block uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            wr_in_pkt <= 1'b0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (data_i.flit_label == HEAD) begin
                    wr_in_pkt <= 1'b1;
                end else if (data_i.flit_label == TAIL) begin
                    wr_in_pkt <= 1'b0;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Hysteretic upstream flow control, evaluated on the post-update occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_off_o <= 1'b1;
        end else if (on_off_o && (count_next >= CNT_W'(OFF_THRESHOLD))) begin
            on_off_o <= 1'b0;
        end else if (!on_off_o && (count_next <= CNT_W'(ON_THRESHOLD))) begin
            on_off_o <= 1'b1;
        end
    end

    // Packet state machine: next state, latched route/VC, pending head and pulses.
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_next         = state;
        out_port_next      = out_port_o;
        downstream_vc_next = downstream_vc_o;
        pending_v_next     = pending_v;
        pending_port_next  = pending_port;
        fsm_err            = 1'b0;
        alloc_next         = 1'b0;
        vc_request_o       = 1'b0;
        switch_request_o   = 1'b0;

        case (state)
            S_IDLE: begin
                if (head_push) begin
                    state_next    = S_VA;
                    out_port_next = out_port_i;
                end
                if (read_i || vc_valid_i) begin
                    fsm_err = 1'b1;
                end
            end

            S_VA: begin
                vc_request_o = 1'b1;
                if (vc_valid_i) begin
                    state_next         = S_SA;
                    downstream_vc_next = vc_new_i;
                end
                if (read_i) begin
                    fsm_err = 1'b1;
                end
                if (head_push) begin
                    pending_v_next    = 1'b1;
                    pending_port_next = out_port_i;
                end
            end

            S_SA: begin
                switch_request_o = !is_empty_o;
                if ((read_i && is_empty_o) || vc_valid_i) begin
                    fsm_err = 1'b1;
                end
                if (tail_pop) begin
                    alloc_next = 1'b1;
                    if (pending_v) begin
                        state_next     = S_VA;
                        out_port_next  = pending_port;
                        pending_v_next = 1'b0;
                    end else if (head_push) begin
                        // Next head arrives exactly as the tail leaves: go straight to VA.
                        state_next    = S_VA;
                        out_port_next = out_port_i;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (head_push) begin
                    pending_v_next    = 1'b1;
                    pending_port_next = out_port_i;
                end
            end

            default: begin
                state_next = S_IDLE;
                fsm_err    = 1'b1;
                alloc_next = 1'b1;
            end
        endcase
    end

    // State register plus the registered FSM outputs and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            out_port_o       <= LOCAL;
            downstream_vc_o  <= '0;
            pending_v        <= 1'b0;
            pending_port     <= LOCAL;
            error_o          <= 1'b0;
            vc_allocatable_o <= 1'b0;
        end else begin
            state            <= state_next;
            out_port_o       <= out_port_next;
            downstream_vc_o  <= downstream_vc_next;
            pending_v        <= pending_v_next;
            pending_port     <= pending_port_next;
            error_o          <= fsm_err || write_err;
            vc_allocatable_o <= alloc_next;
        end
    end

`ifdef INPUT_VC_BUFFER_STATS_EN
    // Saturating counters of delivered packets and dropped writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_o  <= '0;
            drop_count_o <= '0;
        end else begin
            if (tail_pop && (pkt_count_o != 16'hFFFF)) begin
                pkt_count_o <= pkt_count_o + 16'd1;
            end
            if (write_err && (drop_count_o != 16'hFFFF)) begin
                drop_count_o <= drop_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed testbench for input_vc_buffer (default parameters: depth 8,
// watermarks 6/2, ALLOW_NEXT_HEAD=1). Inputs change 1 ns after the rising
// edge; outputs are sampled at that point, well away from the next edge.

module tb_input_vc_buffer;
    import input_vc_buffer_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               write_i;
    flit_novc_t         data_i;
    port_t              out_port_i;
    logic               read_i;
    flit_t              data_o;
    logic               is_full_o;
    logic               is_empty_o;
    logic [3:0]         occupancy_o;
    logic               on_off_o;
    logic               vc_request_o;
    logic               vc_valid_i;
    logic [VC_SIZE-1:0] vc_new_i;
    logic [VC_SIZE-1:0] downstream_vc_o;
    port_t              out_port_o;
    logic               switch_request_o;
    logic               vc_allocatable_o;
    logic               error_o;
`ifdef INPUT_VC_BUFFER_STATS_EN
    logic [15:0]        pkt_count_o;
    logic [15:0]        drop_count_o;
`endif

    int errors = 0;
    int checks = 0;

    input_vc_buffer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .write_i          (write_i),
        .data_i           (data_i),
        .out_port_i       (out_port_i),
        .read_i           (read_i),
        .data_o           (data_o),
        .is_full_o        (is_full_o),
        .is_empty_o       (is_empty_o),
        .occupancy_o      (occupancy_o),
        .on_off_o         (on_off_o),
        .vc_request_o     (vc_request_o),
        .vc_valid_i       (vc_valid_i),
        .vc_new_i         (vc_new_i),
        .downstream_vc_o  (downstream_vc_o),
        .out_port_o       (out_port_o),
        .switch_request_o (switch_request_o),
        .vc_allocatable_o (vc_allocatable_o),
`ifdef INPUT_VC_BUFFER_STATS_EN
        .pkt_count_o      (pkt_count_o),
        .drop_count_o     (drop_count_o),
`endif
        .error_o          (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        write_i    = 1'b0;
        data_i     = '{flit_label: BODY, data: 16'h0};
        out_port_i = LOCAL;
        read_i     = 1'b0;
        vc_valid_i = 1'b0;
        vc_new_i   = '0;
    endtask

    task automatic set_write(input flit_label_t l, input logic [15:0] d, input port_t p);
        write_i    = 1'b1;
        data_i     = '{flit_label: l, data: d};
        out_port_i = p;
    endtask

    task automatic grant(input logic [VC_SIZE-1:0] vc);
        vc_valid_i = 1'b1;
        vc_new_i   = vc;
        step();
        drive_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occupancy_o); end
        checks++; if (is_empty_o !== 1'b1 || is_full_o !== 1'b0) begin errors++; $display("FAIL rst_flags: empty=%b full=%b want 1 0", is_empty_o, is_full_o); end
        checks++; if (on_off_o !== 1'b1) begin errors++; $display("FAIL rst_on_off: got %b want 1", on_off_o); end
        checks++; if (out_port_o !== LOCAL || downstream_vc_o !== 2'd0) begin errors++; $display("FAIL rst_route: port=%0d vc=%0d want 0 0", out_port_o, downstream_vc_o); end
        checks++; if ({vc_request_o, switch_request_o, vc_allocatable_o, error_o} !== 4'b0000) begin errors++; $display("FAIL rst_pulses: got %b want 0000", {vc_request_o, switch_request_o, vc_allocatable_o, error_o}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_headtail();
        set_write(HEADTAIL, 16'hA5A5, NORTH);
        step();
        drive_idle();
        checks++; if (occupancy_o !== 4'd1) begin errors++; $display("FAIL ht_occ: got %0d want 1", occupancy_o); end
        checks++; if (vc_request_o !== 1'b1) begin errors++; $display("FAIL ht_vc_req: got %b want 1", vc_request_o); end
        checks++; if (out_port_o !== NORTH) begin errors++; $display("FAIL ht_port: got %0d want %0d", out_port_o, NORTH); end
        checks++; if (data_o.flit_label !== HEADTAIL || data_o.data !== 16'hA5A5) begin errors++; $display("FAIL ht_data: got %0d/%h want %0d/a5a5", data_o.flit_label, data_o.data, HEADTAIL); end
        grant(2'd2);
        checks++; if (switch_request_o !== 1'b1 || vc_request_o !== 1'b0) begin errors++; $display("FAIL ht_sa: sw=%b vc=%b want 1 0", switch_request_o, vc_request_o); end
        checks++; if (data_o.vc_id !== 2'd2 || downstream_vc_o !== 2'd2) begin errors++; $display("FAIL ht_vc_id: got %0d/%0d want 2", data_o.vc_id, downstream_vc_o); end
        read_i = 1'b1;
        step();
        drive_idle();
        checks++; if (vc_allocatable_o !== 1'b1) begin errors++; $display("FAIL ht_alloc: got %b want 1", vc_allocatable_o); end
        checks++; if (is_empty_o !== 1'b1 || switch_request_o !== 1'b0 || vc_request_o !== 1'b0) begin errors++; $display("FAIL ht_idle: empty=%b sw=%b vc=%b want 1 0 0", is_empty_o, switch_request_o, vc_request_o); end
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL ht_err: got %b want 0", error_o); end
        step();
        checks++; if (vc_allocatable_o !== 1'b0) begin errors++; $display("FAIL ht_alloc_pulse: got %b want 0", vc_allocatable_o); end
    endtask

    task automatic test_packet();
        flit_label_t labels [5];
        labels = '{HEAD, BODY, BODY, BODY, TAIL};
        for (int i = 0; i < 5; i++) begin
            set_write(labels[i], 16'h1000 + 16'(i), SOUTH);
            step();
        end
        drive_idle();
        checks++; if (occupancy_o !== 4'd5 || on_off_o !== 1'b1) begin errors++; $display("FAIL pkt_fill: occ=%0d on=%b want 5 1", occupancy_o, on_off_o); end
        checks++; if (out_port_o !== SOUTH) begin errors++; $display("FAIL pkt_port: got %0d want %0d", out_port_o, SOUTH); end
        grant(2'd1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (occupancy_o !== 4'(5 - i)) begin errors++; $display("FAIL pkt_occ%0d: got %0d want %0d", i, occupancy_o, 5 - i); end
            checks++; if (switch_request_o !== 1'b1) begin errors++; $display("FAIL pkt_sw%0d: got %b want 1", i, switch_request_o); end
            checks++; if (data_o.data !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL pkt_data%0d: got %h want %h", i, data_o.data, 16'h1000 + 16'(i)); end
            read_i = 1'b1;
            step();
            drive_idle();
        end
        checks++; if (occupancy_o !== 4'd0 || switch_request_o !== 1'b0) begin errors++; $display("FAIL pkt_drain: occ=%0d sw=%b want 0 0", occupancy_o, switch_request_o); end
        checks++; if (vc_allocatable_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL pkt_end: alloc=%b err=%b want 1 0", vc_allocatable_o, error_o); end
        step();
    endtask

    task automatic test_watermark();
        logic exp_on;
        for (int i = 0; i < 6; i++) begin
            set_write((i == 0) ? HEAD : BODY, 16'h2000 + 16'(i), NORTH);
            step();
            drive_idle();
            exp_on = (i + 1 >= 6) ? 1'b0 : 1'b1;
            checks++; if (on_off_o !== exp_on) begin errors++; $display("FAIL wm_fill%0d: on_off=%b want %b", i + 1, on_off_o, exp_on); end
        end
        grant(2'd0);
        for (int k = 1; k <= 4; k++) begin
            read_i = 1'b1;
            step();
            drive_idle();
            exp_on = (6 - k <= 2) ? 1'b1 : 1'b0;
            checks++; if (occupancy_o !== 4'(6 - k) || on_off_o !== exp_on) begin errors++; $display("FAIL wm_pop%0d: occ=%0d on=%b want %0d %b", k, occupancy_o, on_off_o, 6 - k, exp_on); end
        end
        set_write(TAIL, 16'h20FF, NORTH);
        step();
        drive_idle();
        checks++; if (occupancy_o !== 4'd3 || on_off_o !== 1'b1) begin errors++; $display("FAIL wm_tail: occ=%0d on=%b want 3 1", occupancy_o, on_off_o); end
        read_i = 1'b1;
        repeat (3) step();
        drive_idle();
        checks++; if (is_empty_o !== 1'b1 || vc_allocatable_o !== 1'b1) begin errors++; $display("FAIL wm_drain: empty=%b alloc=%b want 1 1", is_empty_o, vc_allocatable_o); end
        step();
    endtask

    task automatic test_next_head();
        set_write(HEAD, 16'h3000, WEST); step();
        set_write(BODY, 16'h3001, WEST); step();
        set_write(TAIL, 16'h3002, WEST); step();
        drive_idle();
        grant(2'd0);
        set_write(HEAD, 16'h4000, EAST);
        step();
        drive_idle();
        checks++; if (occupancy_o !== 4'd4 || out_port_o !== WEST || error_o !== 1'b0) begin errors++; $display("FAIL nh_pending: occ=%0d port=%0d err=%b want 4 %0d 0", occupancy_o, out_port_o, error_o, WEST); end
        set_write(TAIL, 16'h4001, LOCAL);
        step();
        drive_idle();
        read_i = 1'b1;
        repeat (3) step();
        drive_idle();
        checks++; if (vc_request_o !== 1'b1 || out_port_o !== EAST) begin errors++; $display("FAIL nh_va: vc_req=%b port=%0d want 1 %0d", vc_request_o, out_port_o, EAST); end
        checks++; if (vc_allocatable_o !== 1'b1 || occupancy_o !== 4'd2) begin errors++; $display("FAIL nh_alloc: alloc=%b occ=%0d want 1 2", vc_allocatable_o, occupancy_o); end
        checks++; if (data_o.data !== 16'h4000) begin errors++; $display("FAIL nh_head: got %h want 4000", data_o.data); end
        read_i = 1'b1;
        step();
        drive_idle();
        checks++; if (error_o !== 1'b1 || occupancy_o !== 4'd2) begin errors++; $display("FAIL nh_read_va: err=%b occ=%0d want 1 2", error_o, occupancy_o); end
        grant(2'd3);
        checks++; if (error_o !== 1'b0 || downstream_vc_o !== 2'd3) begin errors++; $display("FAIL nh_grant: err=%b vc=%0d want 0 3", error_o, downstream_vc_o); end
        read_i = 1'b1;
        repeat (2) step();
        drive_idle();
        checks++; if (is_empty_o !== 1'b1 || vc_allocatable_o !== 1'b1 || vc_request_o !== 1'b0) begin errors++; $display("FAIL nh_drain: empty=%b alloc=%b vc=%b want 1 1 0", is_empty_o, vc_allocatable_o, vc_request_o); end
        step();
    endtask

    task automatic test_errors();
        set_write(BODY, 16'h5555, LOCAL);
        step();
        drive_idle();
        checks++; if (error_o !== 1'b1 || occupancy_o !== 4'd0) begin errors++; $display("FAIL err_body_idle: err=%b occ=%0d want 1 0", error_o, occupancy_o); end
        read_i = 1'b1;
        step();
        drive_idle();
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL err_read_idle: got %b want 1", error_o); end
        step();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL err_sticky: got %b want 0", error_o); end
        for (int i = 0; i < 8; i++) begin
            set_write((i == 0) ? HEAD : BODY, 16'h6000 + 16'(i), SOUTH);
            step();
        end
        drive_idle();
        checks++; if (is_full_o !== 1'b1 || occupancy_o !== 4'd8) begin errors++; $display("FAIL err_fill: full=%b occ=%0d want 1 8", is_full_o, occupancy_o); end
        set_write(BODY, 16'h6666, SOUTH);
        step();
        drive_idle();
        checks++; if (error_o !== 1'b1 || occupancy_o !== 4'd8) begin errors++; $display("FAIL err_full_wr: err=%b occ=%0d want 1 8", error_o, occupancy_o); end
        grant(2'd1);
        set_write(BODY, 16'h6008, SOUTH);
        read_i = 1'b1;
        step();
        set_write(TAIL, 16'h6009, SOUTH);
        read_i = 1'b1;
        step();
        drive_idle();
        checks++; if (occupancy_o !== 4'd8 || is_full_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL err_full_rw: occ=%0d full=%b err=%b want 8 1 0", occupancy_o, is_full_o, error_o); end
        checks++; if (data_o.data !== 16'h6002) begin errors++; $display("FAIL err_full_head: got %h want 6002", data_o.data); end
        read_i = 1'b1;
        repeat (8) step();
        drive_idle();
        checks++; if (is_empty_o !== 1'b1 || vc_allocatable_o !== 1'b1) begin errors++; $display("FAIL err_drain: empty=%b alloc=%b want 1 1", is_empty_o, vc_allocatable_o); end
        step();
    endtask

    task automatic test_reset_mid();
        set_write(HEAD, 16'h7000, NORTH); step();
        set_write(BODY, 16'h7001, NORTH); step();
        drive_idle();
        grant(2'd2);
        checks++; if (switch_request_o !== 1'b1 || occupancy_o !== 4'd2) begin errors++; $display("FAIL rm_pre: sw=%b occ=%0d want 1 2", switch_request_o, occupancy_o); end
        rst_n = 1'b0;
        #2;
        checks++; if (occupancy_o !== 4'd0 || is_empty_o !== 1'b1) begin errors++; $display("FAIL rm_occ: occ=%0d empty=%b want 0 1", occupancy_o, is_empty_o); end
        checks++; if (switch_request_o !== 1'b0 || vc_request_o !== 1'b0) begin errors++; $display("FAIL rm_req: sw=%b vc=%b want 0 0", switch_request_o, vc_request_o); end
        checks++; if (out_port_o !== LOCAL || downstream_vc_o !== 2'd0 || on_off_o !== 1'b1) begin errors++; $display("FAIL rm_regs: port=%0d vc=%0d on=%b want 0 0 1", out_port_o, downstream_vc_o, on_off_o); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_write(HEAD, 16'h8000, EAST);
        step();
        drive_idle();
        checks++; if (occupancy_o !== 4'd1 || vc_request_o !== 1'b1 || out_port_o !== EAST) begin errors++; $display("FAIL rm_new_head: occ=%0d vc=%b port=%0d want 1 1 %0d", occupancy_o, vc_request_o, out_port_o, EAST); end
        checks++; if (error_o !== 1'b0 || data_o.data !== 16'h8000) begin errors++; $display("FAIL rm_new_data: err=%b data=%h want 0 8000", error_o, data_o.data); end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_headtail();
        test_packet();
        test_watermark();
        test_next_head();
        test_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
